// File: rtl/add64_scheduler_if.sv
// Request/operand bus between two requesters and the shared serial 64-bit adder.
// The master modport is the requester side; the slave modport is the adder side.
interface add64_scheduler_if;
    logic        req0;
    logic        req1;
    logic [63:0] x0;
    logic [63:0] y0;
    logic [63:0] x1;
    logic [63:0] y1;
    logic        carry_in0;
    logic        carry_in1;
    logic        grant0;
    logic        grant1;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [63:0] sum;
    logic        carry_out;

    modport master (
        output req0, req1, x0, y0, x1, y1, carry_in0, carry_in1,
        input  grant0, grant1, busy, done, done_id, sum, carry_out
    );

    modport slave (
        input  req0, req1, x0, y0, x1, y1, carry_in0, carry_in1,
        output grant0, grant1, busy, done, done_id, sum, carry_out
    );
endinterface

// File: rtl/add64_scheduler.sv
// Two-requester 64-bit adder built on one 4-bit slice: 1 grant cycle plus 16 nibble cycles per op,
// result after 16 RUN edges; requests are ignored (never queued) while an addition is in progress.
module add64_scheduler (
    input  logic                      i_clk,
    input  logic                      i_rst,
    add64_scheduler_if.slave          bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_k;
    logic        r_carry;
    logic [63:0] r_x;
    logic [63:0] r_y;
    logic [63:0] r_acc;
    logic        r_last_sel;
    logic        r_grant0;
    logic        r_grant1;
    logic        r_done;
    logic        r_done_id;
    logic [63:0] r_sum;
    logic        r_carry_out;

    logic        w_start;
    logic        w_win;
    logic        w_finish;
    logic [5:0]  w_nib_base;
    logic [3:0]  w_x_nib;
    logic [3:0]  w_y_nib;
    logic [4:0]  w_nib;
    logic [63:0] w_acc_nxt;

    // Shared 4-bit slice: current nibble of each operand plus the running carry.
    always_comb begin
        w_nib_base = {r_k, 2'b00};
        w_x_nib    = r_x[w_nib_base +: 4];
        w_y_nib    = r_y[w_nib_base +: 4];
        w_nib      = {1'b0, w_x_nib} + {1'b0, w_y_nib} + {4'b0000, r_carry};
        w_acc_nxt  = r_acc;
        w_acc_nxt[w_nib_base +: 4] = w_nib[3:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_win       = r_last_sel;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_start     = 1'b1;
                    w_state_nxt = RUN;
                    // On contention the requester not served last wins.
                    if (bus.req0 && bus.req1) begin
                        w_win = ~r_last_sel;
                    end else begin
                        w_win = bus.req1;
                    end
                end
            end
            RUN: begin
                if (r_k == 4'd15) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_k         <= 4'd0;
            r_carry     <= 1'b0;
            r_x         <= 64'd0;
            r_y         <= 64'd0;
            r_acc       <= 64'd0;
            r_last_sel  <= 1'b1;
            r_grant0    <= 1'b0;
            r_grant1    <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= 1'b0;
            r_sum       <= 64'd0;
            r_carry_out <= 1'b0;
        end else begin
            r_grant0 <= w_start && !w_win;
            r_grant1 <= w_start && w_win;
            r_done   <= w_finish;
            if (w_start) begin
                r_x        <= w_win ? bus.x1 : bus.x0;
                r_y        <= w_win ? bus.y1 : bus.y0;
                r_carry    <= w_win ? bus.carry_in1 : bus.carry_in0;
                r_k        <= 4'd0;
                r_last_sel <= w_win;
            end else if (r_state == RUN) begin
                r_acc   <= w_acc_nxt;
                r_carry <= w_nib[4];
                r_k     <= r_k + 4'd1;
            end
            // Result registers take the accumulator including the nibble finished this edge.
            if (w_finish) begin
                r_sum       <= w_acc_nxt;
                r_carry_out <= w_nib[4];
                r_done_id   <= r_last_sel;
            end
        end
    end

    assign bus.grant0    = r_grant0;
    assign bus.grant1    = r_grant1;
    assign bus.busy      = (r_state == RUN);
    assign bus.done      = r_done;
    assign bus.done_id   = r_done_id;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;

    a_grant_exclusive: assert property (@(posedge i_clk) disable iff (i_rst)
        !(r_grant0 && r_grant1));
    a_done_not_with_grant: assert property (@(posedge i_clk) disable iff (i_rst)
        !(r_done && (r_grant0 || r_grant1)));

endmodule

// File: tb/tb_add64_scheduler.sv
// Randomised self-checking bench for add64_scheduler against a 65-bit arithmetic reference.
module tb_add64_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    add64_scheduler_if bus ();

    add64_scheduler dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {64'd0, c};
    endfunction

    task automatic clear_inputs;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.carry_in0 = 1'b0; bus.carry_in1 = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Ticks until Done (bounded); reports cycles taken and what was seen on the way.
    task automatic wait_done(output int n, output int busy_n, output int g0_n, output int g1_n);
        n = 0; busy_n = 0; g0_n = 0; g1_n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
            if (bus.busy) busy_n++;
            if (bus.grant0) g0_n++;
            if (bus.grant1) g1_n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        #2;
        checks++;
        if ({bus.grant0, bus.grant1, bus.busy, bus.done, bus.done_id, bus.carry_out} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000000",
                     {bus.grant0, bus.grant1, bus.busy, bus.done, bus.done_id, bus.carry_out});
        end
        checks++;
        if (bus.sum !== 64'd0) begin
            errors++;
            $display("FAIL reset_sum got=%h want=0", bus.sum);
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int n, bn, g0, g1;
        bus.req0 = 1'b1; bus.x0 = 64'd1; bus.y0 = '1; bus.carry_in0 = 1'b0;
        tick();
        checks++;
        if (bus.grant0 !== 1'b1 || bus.grant1 !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_grant got g0=%b g1=%b busy=%b want 1 0 1", bus.grant0, bus.grant1, bus.busy);
        end
        bus.req0 = 1'b0;
        wait_done(n, bn, g0, g1);
        checks++;
        if (n !== 16 || bn !== 15 || g0 !== 0 || g1 !== 0) begin
            errors++;
            $display("FAIL basic_timing got n=%0d busy=%0d g0=%0d g1=%0d want 16 15 0 0", n, bn, g0, g1);
        end
        checks++;
        if (bus.sum !== 64'd0 || bus.carry_out !== 1'b1 || bus.done_id !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got sum=%h co=%b id=%b busy=%b want 0 1 0 0",
                     bus.sum, bus.carry_out, bus.done_id, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.sum !== 64'd0 || bus.carry_out !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold got done=%b sum=%h co=%b want 0 0 1", bus.done, bus.sum, bus.carry_out);
        end
    endtask

    task automatic test_contention;
        int n, bn, g0, g1;
        logic [64:0] e0, e1;
        do_reset();
        bus.x0 = {$urandom, $urandom}; bus.y0 = {$urandom, $urandom}; bus.carry_in0 = 1'b1;
        bus.x1 = {$urandom, $urandom}; bus.y1 = {$urandom, $urandom}; bus.carry_in1 = 1'b0;
        e0 = ref_add(bus.x0, bus.y0, 1'b1);
        e1 = ref_add(bus.x1, bus.y1, 1'b0);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick();
        checks++;
        if (bus.grant0 !== 1'b1 || bus.grant1 !== 1'b0) begin
            errors++;
            $display("FAIL contend_first got g0=%b g1=%b want 1 0", bus.grant0, bus.grant1);
        end
        bus.req0 = 1'b0;
        wait_done(n, bn, g0, g1);
        checks++;
        if ({bus.carry_out, bus.sum} !== e0 || bus.done_id !== 1'b0 || g1 !== 0) begin
            errors++;
            $display("FAIL contend_r0 got %h id=%b g1=%0d want %h id=0 g1=0", {bus.carry_out, bus.sum}, bus.done_id, g1, e0);
        end
        tick();
        checks++;
        if (bus.grant1 !== 1'b1 || bus.grant0 !== 1'b0) begin
            errors++;
            $display("FAIL contend_second got g0=%b g1=%b want 0 1", bus.grant0, bus.grant1);
        end
        bus.req1 = 1'b0;
        wait_done(n, bn, g0, g1);
        checks++;
        if ({bus.carry_out, bus.sum} !== e1 || bus.done_id !== 1'b1 || n !== 16) begin
            errors++;
            $display("FAIL contend_r1 got %h id=%b n=%0d want %h id=1 n=16", {bus.carry_out, bus.sum}, bus.done_id, n, e1);
        end
    endtask

    task automatic test_alternate;
        int n, bn, g0, g1, w;
        logic [64:0] e;
        logic want_id;
        do_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int op = 0; op < 4; op++) begin
            want_id = op[0];
            w = 0;
            tick();
            while (!bus.grant0 && !bus.grant1 && w < 20) begin
                tick();
                w++;
            end
            // Operands seen at the granting edge are still on the bus here.
            e = want_id ? ref_add(bus.x1, bus.y1, bus.carry_in1) : ref_add(bus.x0, bus.y0, bus.carry_in0);
            checks++;
            if (bus.grant0 !== !want_id || bus.grant1 !== want_id || w !== 0) begin
                errors++;
                $display("FAIL alt_grant op=%0d got g0=%b g1=%b wait=%0d want id=%b wait=0",
                         op, bus.grant0, bus.grant1, w, want_id);
            end
            bus.x0 = {$urandom, $urandom}; bus.y0 = {$urandom, $urandom}; bus.carry_in0 = $urandom_range(0, 1);
            bus.x1 = {$urandom, $urandom}; bus.y1 = {$urandom, $urandom}; bus.carry_in1 = $urandom_range(0, 1);
            wait_done(n, bn, g0, g1);
            checks++;
            if ({bus.carry_out, bus.sum} !== e || bus.done_id !== want_id || g0 !== 0 || g1 !== 0) begin
                errors++;
                $display("FAIL alt_result op=%0d got %h id=%b g=%0d/%0d want %h id=%b no grants",
                         op, {bus.carry_out, bus.sum}, bus.done_id, g0, g1, e, want_id);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        int n, bn, g0, g1, dn;
        do_reset();
        bus.req0 = 1'b1; bus.x0 = {$urandom, $urandom}; bus.y0 = {$urandom, $urandom};
        tick();
        bus.req0 = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.grant0, bus.grant1, bus.busy, bus.done, bus.done_id, bus.carry_out} !== 6'b0 || bus.sum !== 64'd0) begin
            errors++;
            $display("FAIL midreset_outputs got flags=%b sum=%h want 0",
                     {bus.grant0, bus.grant1, bus.busy, bus.done, bus.done_id, bus.carry_out}, bus.sum);
        end
        repeat (2) tick();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done || bus.busy) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL midreset_nodone got %0d active cycles want 0", dn);
        end
        bus.req1 = 1'b1; bus.x1 = 64'd0; bus.y1 = 64'd0; bus.carry_in1 = 1'b1;
        tick();
        bus.req1 = 1'b0;
        checks++;
        if (bus.grant1 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_grant got g1=%b want 1", bus.grant1);
        end
        wait_done(n, bn, g0, g1);
        checks++;
        if (bus.sum !== 64'd1 || bus.carry_out !== 1'b0 || bus.done_id !== 1'b1) begin
            errors++;
            $display("FAIL midreset_result got sum=%h co=%b id=%b want 1 0 1", bus.sum, bus.carry_out, bus.done_id);
        end
    endtask

    task automatic test_midrun_req;
        int n, bn, g0, g1;
        tick();
        bus.req0 = 1'b1; bus.x0 = 64'h8000_0000_0000_0000; bus.y0 = 64'h8000_0000_0000_0000; bus.carry_in0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        repeat (5) tick();
        bus.req1 = 1'b1;
        tick();
        bus.req1 = 1'b0;
        wait_done(n, bn, g0, g1);
        checks++;
        if (bus.sum !== 64'd1 || bus.carry_out !== 1'b1 || bus.done_id !== 1'b0 || g1 !== 0) begin
            errors++;
            $display("FAIL midrun_req got sum=%h co=%b id=%b g1=%0d want 1 1 0 0",
                     bus.sum, bus.carry_out, bus.done_id, g1);
        end
        tick();
        checks++;
        if (bus.grant1 !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_ignored got g1=%b busy=%b want 0 0", bus.grant1, bus.busy);
        end
    endtask

    task automatic test_random;
        int n, bn, g0, g1, pat;
        logic last_served, winner;
        logic [64:0] e;
        do_reset();
        last_served = 1'b1;
        for (int op = 0; op < 1000; op++) begin
            pat = $urandom_range(1, 3);
            bus.x0 = {$urandom, $urandom}; bus.y0 = {$urandom, $urandom}; bus.carry_in0 = $urandom_range(0, 1);
            bus.x1 = {$urandom, $urandom}; bus.y1 = {$urandom, $urandom}; bus.carry_in1 = $urandom_range(0, 1);
            if (op % 50 == 0) begin
                bus.x0 = '1; bus.y0 = '1; bus.carry_in0 = 1'b1;
            end
            bus.req0 = pat[0];
            bus.req1 = pat[1];
            winner = (pat == 3) ? !last_served : (pat == 2);
            e = winner ? ref_add(bus.x1, bus.y1, bus.carry_in1) : ref_add(bus.x0, bus.y0, bus.carry_in0);
            tick();
            checks++;
            if (bus.grant0 !== !winner || bus.grant1 !== winner) begin
                errors++;
                $display("FAIL rand_grant op=%0d pat=%0d got g0=%b g1=%b want winner=%b",
                         op, pat, bus.grant0, bus.grant1, winner);
            end
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            last_served = winner;
            wait_done(n, bn, g0, g1);
            checks++;
            if ({bus.carry_out, bus.sum} !== e || bus.done_id !== winner || n !== 16) begin
                errors++;
                $display("FAIL rand_result op=%0d got %h id=%b n=%0d want %h id=%b n=16",
                         op, {bus.carry_out, bus.sum}, bus.done_id, n, e, winner);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_alternate();
        test_reset_mid();
        test_midrun_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
